// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared scalar types for the core datapath
package common;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  creg_addr_t;
    typedef logic [11:0] csr_addr_t;
endpackage

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - inter-stage pipeline records and decode constants
package pipeline;
    import common::*;

    localparam int DECODE_QUEUE_DEPTH = 4;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        word_t pc;
        word_t raw_instr;
    } fetch_data_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src_imm;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       csr_en;
    } control_t;

    typedef struct packed {
        logic       valid;
        word_t      pc;
        control_t   ctl;
        word_t      imm;
        creg_addr_t rs1;
        creg_addr_t rs2;
        creg_addr_t dst;
        word_t      srca;
        word_t      srcb;
        csr_addr_t  csr_addr;
        word_t      csr_data;
    } decode_data_t;
endpackage

// File: rtl/decode_fifo.sv
// rtl/decode_fifo.sv - circular instruction queue with wrap-bit pointers and flush
module decode_fifo
    import pipeline::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       wr_en,
    input  fetch_data_t                wr_data,
    input  logic                       rd_en,
    output fetch_data_t                rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    fetch_data_t   mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW:0]   used;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign used    = wptr - rptr;
    assign count   = used;
    assign rd_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en && !full)
                wptr <= wptr + 1'b1;
            if (rd_en && !empty)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full && !flush && !reset)
            mem[wptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/decoder.sv
// rtl/decoder.sv - combinational instruction decoder (control, immediate, register fields)
module decoder
    import common::*;
    import pipeline::*;
(
    input  word_t      instr,
    output control_t   ctl,
    output word_t      imm,
    output creg_addr_t rs1,
    output creg_addr_t rs2,
    output creg_addr_t dst
);
    always_comb begin
        ctl = '0;
        imm = '0;
        case (instr[6:0])
            OP_REG: begin
                ctl.alu_op    = {instr[30], instr[14:12]};
                ctl.reg_write = 1'b1;
            end
            OP_IMM: begin
                // bit 30 only distinguishes srai from srli among immediates
                ctl.alu_op      = {(instr[14:12] == 3'b101) & instr[30], instr[14:12]};
                ctl.alu_src_imm = 1'b1;
                ctl.reg_write   = 1'b1;
                imm             = {{20{instr[31]}}, instr[31:20]};
            end
            OP_LOAD: begin
                ctl.alu_src_imm = 1'b1;
                ctl.reg_write   = 1'b1;
                ctl.mem_read    = 1'b1;
                imm             = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                ctl.alu_src_imm = 1'b1;
                ctl.mem_write   = 1'b1;
                imm             = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                ctl.branch = 1'b1;
                imm        = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_JAL: begin
                ctl.jump      = 1'b1;
                ctl.reg_write = 1'b1;
                imm           = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_LUI: begin
                ctl.alu_src_imm = 1'b1;
                ctl.reg_write   = 1'b1;
                imm             = {instr[31:12], 12'b0};
            end
            OP_SYSTEM: begin
                ctl.csr_en    = 1'b1;
                ctl.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign dst = ctl.reg_write ? instr[11:7] : '0;
endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - buffered decode stage with load-use interlock; DECODE_BYPASS_EN enables empty-queue bypass
module decode_queue
    import common::*;
    import pipeline::*;
#(
    parameter int DEPTH = DECODE_QUEUE_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  fetch_data_t                in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output decode_data_t               out_data,
    input  logic                       flush,
    input  logic                       ex_load,
    input  creg_addr_t                 ex_dst,
    output creg_addr_t                 ra1,
    output creg_addr_t                 ra2,
    input  word_t                      rd1,
    input  word_t                      rd2,
    output csr_addr_t                  csr_addr,
    input  word_t                      csr_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    fetch_data_t  head;
    fetch_data_t  cand;
    logic         fifo_full;
    logic         fifo_empty;
    logic         cand_valid;
    logic         hazard;
    logic         issue;
    logic         enq;
    logic         deq;
    word_t        cand_instr;
    control_t     dec_ctl;
    word_t        dec_imm;
    creg_addr_t   dec_rs1;
    creg_addr_t   dec_rs2;
    creg_addr_t   dec_dst;
    decode_data_t slot;

    assign in_ready = !fifo_full && !flush && !reset;

`ifdef DECODE_BYPASS_EN
    logic use_bypass;
    assign use_bypass = fifo_empty && in_valid && in_ready;
    assign cand_valid = !fifo_empty || use_bypass;
    assign cand       = fifo_empty ? in_data : head;
    // a bypassed instruction is written only when it could not issue directly
    assign enq        = in_valid && in_ready && !(use_bypass && issue);
`else
    assign cand_valid = !fifo_empty;
    assign cand       = head;
    assign enq        = in_valid && in_ready;
`endif

    assign deq = issue && !fifo_empty;

    decode_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .wr_en   (enq),
        .wr_data (in_data),
        .rd_en   (deq),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    // zeroing the instruction with no candidate also zeroes the read ports
    assign cand_instr = cand_valid ? cand.raw_instr : '0;

    decoder u_dec (
        .instr (cand_instr),
        .ctl   (dec_ctl),
        .imm   (dec_imm),
        .rs1   (dec_rs1),
        .rs2   (dec_rs2),
        .dst   (dec_dst)
    );

    assign ra1      = dec_rs1;
    assign ra2      = dec_rs2;
    assign csr_addr = cand_instr[31:20];

    assign hazard = cand_valid && ex_load && (ex_dst != '0) &&
                    ((dec_rs1 == ex_dst) || (dec_rs2 == ex_dst));
    assign issue  = cand_valid && !hazard && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            slot <= '0;
        end else if (issue) begin
            slot <= '{valid:    1'b1,
                      pc:       cand.pc,
                      ctl:      dec_ctl,
                      imm:      dec_imm,
                      rs1:      dec_rs1,
                      rs2:      dec_rs2,
                      dst:      dec_dst,
                      srca:     rd1,
                      srcb:     rd2,
                      csr_addr: cand_instr[31:20],
                      csr_data: csr_data};
        end else if (out_ready) begin
            slot <= '0;
        end
    end

    assign out_valid = slot.valid;
    assign out_data  = slot;
endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - directed self-checking bench for decode_queue
module tb_decode_queue;
    import common::*;
    import pipeline::*;

`ifdef DECODE_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif
    localparam word_t ADD  = 32'h007302B3;
    localparam word_t ADDI = 32'hFFB10093;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    fetch_data_t  in_data;
    logic         out_valid;
    logic         out_ready;
    decode_data_t out_data;
    logic         flush;
    logic         ex_load;
    creg_addr_t   ex_dst;
    creg_addr_t   ra1;
    creg_addr_t   ra2;
    word_t        rd1;
    word_t        rd2;
    csr_addr_t    csr_addr;
    word_t        csr_data;
    logic [$clog2(DECODE_QUEUE_DEPTH+1)-1:0] count;
    word_t        rd1_ofs;
    control_t     addi_ctl;
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    assign rd1      = 32'h1000_0000 + {27'b0, ra1} + rd1_ofs;
    assign rd2      = 32'h2000_0000 + {27'b0, ra2};
    assign csr_data = {20'hC0000, csr_addr};

    decode_queue dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .ex_load   (ex_load),
        .ex_dst    (ex_dst),
        .ra1       (ra1),
        .ra2       (ra2),
        .rd1       (rd1),
        .rd2       (rd2),
        .csr_addr  (csr_addr),
        .csr_data  (csr_data),
        .count     (count)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic decode_data_t exp_add(input word_t pc);
        decode_data_t d;
        d               = '0;
        d.valid         = 1'b1;
        d.pc            = pc;
        d.ctl.reg_write = 1'b1;
        d.rs1           = 5'd6;
        d.rs2           = 5'd7;
        d.dst           = 5'd5;
        d.srca          = 32'h1000_0006;
        d.srcb          = 32'h2000_0007;
        d.csr_addr      = 12'h007;
        d.csr_data      = 32'hC000_0007;
        return d;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input word_t pc, input word_t instr);
        in_valid          = 1'b1;
        in_data.pc        = pc;
        in_data.raw_instr = instr;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        flush = 1'b0; ex_load = 1'b0; ex_dst = '0; rd1_ofs = '0;
        addi_ctl = '0; addi_ctl.alu_src_imm = 1'b1; addi_ctl.reg_write = 1'b1;
        tick; tick;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_count", count, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        check("idle_ra1", ra1, 0);
        check("idle_csr_addr", csr_addr, 0);

        // fill then drain
        for (int i = 0; i < 5; i++) begin
            push(32'h100 + 4 * i, ADD);
            tick;
        end
        in_valid = 1'b0;
        #1;
        check("fill_count", count, 4);
        check("fill_in_ready", in_ready, 1'b0);
        check("fill_slot", out_data, exp_add(32'h100));
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick;
            check("drain_data", out_data, exp_add(32'h100 + 4 * i));
            check("drain_count", count, 4 - i);
        end
        tick;
        check("drain_empty_valid", out_valid, 1'b0);
        check("drain_empty_data", out_data, '0);

        // load-use interlock
        ex_load = 1'b1; ex_dst = 5'd6;
        push(32'h200, ADD);
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("hazard_ra1", ra1, 6);
            tick;
            check("hazard_stall", out_valid, 1'b0);
            check("hazard_count", count, 1);
        end
        ex_load = 1'b0;
        tick;
        check("hazard_release", out_data, exp_add(32'h200));
        check("hazard_release_count", count, 0);

        // ex_dst of x0 never stalls
        ex_load = 1'b1; ex_dst = 5'd0;
        push(32'h204, ADD);
        tick;
        in_valid = 1'b0;
        check("x0_first_cycle", out_valid, LAT == 1);
        if (LAT == 2) tick;
        check("x0_no_stall", out_data, exp_add(32'h204));
        ex_load = 1'b0;
        tick;
        check("x0_clear", out_valid, 1'b0);

        // latency and immediate decode of addi x1,x2,-5
        push(32'h600, ADDI);
        tick;
        in_valid = 1'b0;
        check("lat_first_cycle", out_valid, LAT == 1);
        if (LAT == 2) tick;
        check("lat_valid", out_valid, 1'b1);
        check("addi_pc", out_data.pc, 32'h600);
        check("addi_imm", out_data.imm, 32'hFFFF_FFFB);
        check("addi_dst", out_data.dst, 1);
        check("addi_ctl", out_data.ctl, addi_ctl);
        check("addi_srca", out_data.srca, 32'h1000_0002);
        tick;

        // back-pressure hold while register data moves underneath
        out_ready = 1'b0;
        push(32'h300, ADD);
        tick;
        in_valid = 1'b0;
        if (LAT == 2) tick;
        check("hold_capture", out_data, exp_add(32'h300));
        for (int i = 0; i < 4; i++) begin
            rd1_ofs = 32'h55 * (i + 1);
            tick;
            check("hold_data", out_data, exp_add(32'h300));
        end
        rd1_ofs = '0;
        out_ready = 1'b1;
        tick;
        check("hold_release", out_valid, 1'b0);

        // flush while full
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(32'h400 + 4 * i, ADD);
            tick;
        end
        check("flush_full_count", count, 4);
        flush = 1'b1;
        push(32'h4F0, ADD);
        #1;
        check("flush_in_ready", in_ready, 1'b0);
        tick;
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_count", count, 0);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready_after", in_ready, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("flush_no_ghost", out_valid, 1'b0);
        end

        // wrap-around streaming
        for (int k = 0; k < 10; k++) begin
            push(32'h500 + 4 * k, ADD);
            tick;
            if (k >= LAT - 1)
                check("wrap_order", out_data.pc, 32'h500 + 4 * (k - (LAT - 1)));
            check("wrap_count", count <= 1, 1'b1);
        end
        in_valid = 1'b0;
        if (LAT == 2) tick;
        check("wrap_last", out_data, exp_add(32'h524));
        tick;
        check("wrap_done", out_valid, 1'b0);

        // reset mid-operation
        out_ready = 1'b0;
        push(32'h700, ADD); tick;
        push(32'h704, ADD); tick;
        push(32'h708, ADD); tick;
        in_valid = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("midrst_count", count, 0);
        check("midrst_out_data", out_data, '0);
        out_ready = 1'b1;
        tick;
        check("midrst_no_ghost", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
# decode_queue

Buffered, handshaked decode stage between fetch and execute. Each fetched instruction is held in a DEPTH-entry circular queue, then decoded and given its register/CSR operands. The result is captured in a registered decode_data_t output slot. It adds what the purely combinational decode lacks: back-pressure, flush, a load-use interlock and an occupancy count.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch offers in_data
- in_ready  out  1  queue accepts this cycle
- in_data  in  fetch_data_t  fetched instruction (pc, raw_instr)
- out_valid  out  1  output slot holds a decoded instruction
- out_ready  in  1  execute consumes output this cycle
- out_data  out  decode_data_t  registered decode result
- flush  in  1  discard all buffered and held instructions
- ex_load  in  1  instruction in execute is a load
- ex_dst  in  creg_addr_t  destination of that instruction
- ra1, ra2  out  creg_addr_t  register-file read addresses (rs1/rs2 of issuing instruction)
- rd1, rd2  in  word_t  register-file read data, same cycle
- csr_addr  out  csr_addr_t  raw_instr[31:20] of issuing instruction
- csr_data  in  word_t  CSR read data, same cycle
- count  out  $clog2(DEPTH+1)  queue occupancy, excluding the output slot

## Operation
- **Queue.**
  - Read/write pointers are $clog2(DEPTH)+1 bits, the MSB being the wrap bit.
  - Empty means pointers are equal. Full means the index bits are equal and the wrap bits differ.
  - in_ready = !full && !flush && !reset.
  - Enqueue on in_valid && in_ready.
- **Issue candidate.** The queue head; with the bypass feature and an empty queue, in_data instead.
- **Hazard.** Set when ex_load && ex_dst != 0 && (cand.rs1 == ex_dst || cand.rs2 == ex_dst).
- **Issue.** Occurs when the candidate exists, no hazard is present, and (!out_valid || out_ready).
  - Decoder output, imm, rs1/rs2/dst, rd1→srca, rd2→srcb and csr_addr/csr_data are captured into the output slot.
  - Head dequeues.
- **Output slot.** Holds stable while out_valid && !out_ready. Clears when out_ready and no issue occurs.
- **Operand timing.** Operands are sampled at capture only. Later writebacks are resolved by downstream forwarding, not here.
- **Port drive.** ra1/ra2/csr_addr are driven from the candidate every cycle, or from zero when there is no candidate.
- **Output fields.** out_data.valid mirrors out_valid. out_data.ctl = '0 when !out_valid.
- **Flush.** Highest priority.
  - Next cycle: pointers are equal, count=0, out_valid=0.
  - Same-cycle enqueue and issue are discarded.
- **Simultaneous enqueue+dequeue.**
  - Count is unchanged.
  - When full, no enqueue occurs even if dequeuing (in_ready does not depend on dequeue).

## Timing
- **Reset values.** out_valid=0, out_data='0, count=0, pointers 0. in_ready=0 while reset is high and 1 the cycle after.
- **Latency, in_valid handshake to out_valid:**
  - 2 cycles through the queue.
  - 1 cycle with bypass and an empty queue.
- **Throughput.** One instruction per cycle sustained when out_ready is held high and no hazard occurs.
- **Hazard stall.** Lasts exactly as long as the hazard condition holds. Queue contents are preserved.
- **Reset mid-operation.** Identical to flush plus the reset values above.

## Configuration
- **DECODE_BYPASS_EN defined.**
  - An empty queue lets in_data issue directly in the handshake cycle, without being written.
  - If that issue is blocked, in_data enqueues normally.
- **Undefined.** Every instruction passes through the queue. Minimum latency is 2 cycles.

## Structure
- Package pipeline holds fetch_data_t, decode_data_t and control_t (existing). It also gets the new constant DECODE_QUEUE_DEPTH, used as the top-level DEPTH value.
- Package common holds word_t, creg_addr_t and csr_addr_t.
- New sub-module decode_fifo: storage, pointers, count, full/empty, flush. The existing decoder is instantiated once, on the candidate instruction.

## Test plan
- **Fill then drain.** DEPTH=4, out_ready=0, 5 back-to-back in_valid.
  - Entry 1 issues to the slot, 4 more fill the queue.
  - count=4, in_ready=0.
  - Raise out_ready: pcs emerge in order, one per cycle.
- **Load-use.** Head is add x5,x6,x7; ex_load=1, ex_dst=6 for 3 cycles.
  - out_valid stays 0 for 3 cycles.
  - Issue happens on cycle 4.
  - ex_dst=0 → no stall.
- **Flush while full.**
  - Next cycle: count=0, out_valid=0, in_ready=1.
  - An instruction enqueued in the flush cycle never appears.
- **Back-pressure hold.** out_ready=0 for 4 cycles. out_data is bit-identical each cycle, including srca, even if rd1 changes.
- **Latency.** Single instruction into an empty queue:
  - out_valid one cycle after handshake with DECODE_BYPASS_EN.
  - Two cycles after without it.
- **Wrap-around.** 10 enqueue/dequeue pairs at DEPTH=4 with out_ready=1. Order is preserved, count stays ≤1, and a pointer wrap occurs.
